game_judge: RTL and testbench
=============================

Name: game_judge

Overview:
- Parametrised win/draw judge for an N x N board with K-in-a-row rules; successor to the fixed 3x3 combinational win check.
- On a start request it snapshots the board and scans one anchor cell per cycle across four directions.
- It reports the winner, a per-cell win mask for the display/colour stage, and an optional draw verdict.
- It sits between the board-state register and the display/controller logic.

Parameters:
- N, 3, board dimension (cells per row/column); legal range 3..8.
- K, 3, run length required to win; legal range 2..N.
- Derived, not overridable: CELLS = N*N; AW = $clog2(CELLS).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a judgement; sampled only in IDLE.
- tiles  input  2*CELLS  board; cell i is tiles[2i+1:2i], row-major (i = row*N + col); 00 empty, 01 player 1, 10 player 2, 11 invalid.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse when a scan completes.
- game_over  output  1  high in WON or DRAW (sticky).
- winner  output  2  01/10 winning player; 00 otherwise.
- draw  output  1  high in DRAW.
- win_mask  output  CELLS  bit i set when cell i belongs to the winning run.

Behaviour:
- All outputs are registered. Reset values: busy=0, done=0, game_over=0, winner=00, draw=0, win_mask=0, anchor=0, state IDLE, snapshot=0.
- FSM states: IDLE, SCAN, WON, DRAW.
- IDLE:
  - start=1 at an edge: latch tiles into the snapshot, set anchor=0, enter SCAN, busy=1.
  - start=0: hold.
- SCAN: at each edge, evaluate anchor a = (r,c) in direction order H, V, D, A. A direction qualifies only if its run fits on the board:
  - H: cells (r,c+j), j=0..K-1; requires c+K-1 < N.
  - V: cells (r+j,c); requires r+K-1 < N.
  - D: cells (r+j,c+j); requires both bounds.
  - A: cells (r+j,c-j); requires r+K-1 < N and c-K+1 >= 0.
- Win rule: all K cells equal and the value is 01 or 10. Value 11 never wins but counts as occupied.
- First qualifying win (lowest anchor, then direction order) at an edge:
  - enter WON; winner=value; win_mask = bits of those K cells only.
  - busy=0; done=1 for one cycle.
  - Simultaneous wins: only the first in scan order is reported.
- No win and a = CELLS-1: done=1, busy=0.
  - Draw detection compiled in and every snapshot cell is non-00: enter DRAW, draw=1, game_over=1.
  - Otherwise: return to IDLE with winner=00, win_mask=0.
- No win and a < CELLS-1: anchor increments.
- Latency: a win found at anchor a gives done exactly a+1 cycles after the start edge. A no-win scan gives done CELLS cycles after the start edge.
- tiles changes during SCAN are ignored (snapshot only). start in SCAN, WON or DRAW is ignored.
- WON and DRAW are terminal; game_over, winner, draw and win_mask hold until reset.
- reset asserted mid-scan: next edge returns to reset values. No done pulse is produced for the aborted scan.

Optional Feature:
- Macro: GAME_JUDGE_DRAW_DETECT_EN.
- Defined: full-board-no-win handling enters DRAW as described above.
- Undefined: DRAW state and its full-board check are not built; draw is tied 0; a no-win scan always returns to IDLE.

Test Plan:
- N=3,K=3; cells 6,7,8=10, others 00; start -> done 7 cycles after the start edge; winner=10, win_mask=9'b111000000, game_over=1.
- N=3; cells 2,4,6=01 -> anchor 2 direction A; done after 3 cycles; win_mask=9'b001010100, winner=01.
- N=3; cells 0,1,2,3,6=01 (row 0 and column 0 both win) -> done after 1 cycle; win_mask=9'b000000111 (H wins priority).
- N=3, draw macro defined; full board 01/10/01,10/10/01,01/01/10 (row-major) with no line -> done after 9 cycles; draw=1, game_over=1, winner=00. Same board with macro undefined -> IDLE, game_over=0.
- N=5,K=4; cells 6,12,18,24=10 -> win via anchor 6 direction D; done after 7 cycles; win_mask bits 6,12,18,24 set.
- N=3; start, then reset at the 3rd SCAN cycle -> all outputs return to 0; no done pulse; a new start then behaves normally.

Source files
------------

// File: rtl/game_judge.sv
// game_judge: sequential win/draw judge for an N x N board, K-in-a-row rules.
// A start request in IDLE snapshots the board; one anchor cell is then
// evaluated per clock in direction order H, V, D, A. The first winning run
// found ends the scan in WON. A scan with no win returns to IDLE, or, when
// GAME_JUDGE_DRAW_DETECT_EN is defined and every cell is occupied, ends in
// DRAW. WON and DRAW hold their results until reset.
//
// Ports:
//   clk       - clock, rising edge
//   reset     - synchronous, active-high reset
//   start     - judgement request, sampled only in IDLE
//   tiles     - board, cell i at tiles[2i+1:2i], row-major; 00 empty,
//               01 player 1, 10 player 2, 11 invalid (occupied, never wins)
//   busy      - high while scanning
//   done      - one-cycle pulse when a scan completes
//   game_over - high in WON or DRAW
//   winner    - winning player (01/10), 00 otherwise
//   draw      - high in DRAW (tied 0 when draw detection is not compiled in)
//   win_mask  - bit i set when cell i belongs to the winning run
//
// Optional feature macro: GAME_JUDGE_DRAW_DETECT_EN
//
// State | Meaning
// IDLE  | waiting for start
// SCAN  | evaluating one anchor cell per cycle
// WON   | winning run found; results held until reset
// DRAW  | full board with no win; held until reset
module game_judge #(
  parameter int N = 3,
  parameter int K = 3,
  localparam int CELLS = N * N,
  localparam int AW = $clog2(CELLS),
  localparam int RW = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*CELLS-1:0] tiles,
  output logic               busy,
  output logic               done,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic               draw,
  output logic [CELLS-1:0]   win_mask
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WON  = 2'd2
`ifdef GAME_JUDGE_DRAW_DETECT_EN
    , DRAW = 2'd3
`endif
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [2*CELLS-1:0] r_snap, w_snap_nxt;
  logic [AW-1:0]      r_anchor, w_anchor_nxt;
  logic [RW-1:0]      r_row, w_row_nxt, r_col, w_col_nxt;
  logic               r_busy, w_busy_nxt, r_done, w_done_nxt;
  logic               r_over, w_over_nxt;
  logic [1:0]         r_winner, w_winner_nxt;
  logic [CELLS-1:0]   r_mask, w_mask_nxt;

  // Result packing: {hit, value[1:0], mask[CELLS-1:0]}.
  // A run that does not fit on the board evaluates to no hit.
  function automatic logic [CELLS+2:0] eval_dir(input logic [2*CELLS-1:0] snap,
                                                input int r, input int c,
                                                input int dr, input int dc);
    logic [1:0]       v0;
    logic             ok;
    logic [CELLS-1:0] m;
    int               idx;
    v0 = 2'b00;
    ok = 1'b0;
    m  = '0;
    if ((r + dr*(K-1) < N) && (c + dc*(K-1) < N) && (c + dc*(K-1) >= 0)) begin
      v0 = snap[2*(r*N+c) +: 2];
      ok = (v0 == 2'b01) || (v0 == 2'b10);
      for (int j = 0; j < K; j++) begin
        idx = (r + dr*j)*N + (c + dc*j);
        if (snap[2*idx +: 2] != v0) ok = 1'b0;
        m[idx] = 1'b1;
      end
    end
    if (!ok) m = '0;
    return {ok, v0, m};
  endfunction

  logic [CELLS+2:0] w_h, w_v, w_d, w_a, w_sel;

  always_comb begin
    w_h = eval_dir(r_snap, int'(r_row), int'(r_col), 0, 1);
    w_v = eval_dir(r_snap, int'(r_row), int'(r_col), 1, 0);
    w_d = eval_dir(r_snap, int'(r_row), int'(r_col), 1, 1);
    w_a = eval_dir(r_snap, int'(r_row), int'(r_col), 1, -1);
    // Direction priority: H, V, D, A.
    if (w_h[CELLS+2])      w_sel = w_h;
    else if (w_v[CELLS+2]) w_sel = w_v;
    else if (w_d[CELLS+2]) w_sel = w_d;
    else                   w_sel = w_a;
  end

`ifdef GAME_JUDGE_DRAW_DETECT_EN
  logic r_draw, w_draw_nxt, w_full;
  always_comb begin
    w_full = 1'b1;
    for (int i = 0; i < CELLS; i++)
      if (r_snap[2*i +: 2] == 2'b00) w_full = 1'b0;
  end
  assign draw = r_draw;
`else
  assign draw = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_snap_nxt   = r_snap;
    w_anchor_nxt = r_anchor;
    w_row_nxt    = r_row;
    w_col_nxt    = r_col;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_over_nxt   = r_over;
    w_winner_nxt = r_winner;
    w_mask_nxt   = r_mask;
`ifdef GAME_JUDGE_DRAW_DETECT_EN
    w_draw_nxt   = r_draw;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_snap_nxt   = tiles;
          w_anchor_nxt = '0;
          w_row_nxt    = '0;
          w_col_nxt    = '0;
          w_busy_nxt   = 1'b1;
          w_winner_nxt = 2'b00;
          w_mask_nxt   = '0;
          w_state_nxt  = SCAN;
        end
      end
      SCAN: begin
        if (w_sel[CELLS+2]) begin
          w_state_nxt  = WON;
          w_winner_nxt = w_sel[CELLS+1:CELLS];
          w_mask_nxt   = w_sel[CELLS-1:0];
          w_over_nxt   = 1'b1;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
        end else if (r_anchor == AW'(CELLS-1)) begin
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_winner_nxt = 2'b00;
          w_mask_nxt   = '0;
          w_state_nxt  = IDLE;
`ifdef GAME_JUDGE_DRAW_DETECT_EN
          if (w_full) begin
            w_state_nxt = DRAW;
            w_draw_nxt  = 1'b1;
            w_over_nxt  = 1'b1;
          end
`endif
        end else begin
          w_anchor_nxt = r_anchor + 1'b1;
          if (r_col == RW'(N-1)) begin
            w_col_nxt = '0;
            w_row_nxt = r_row + 1'b1;
          end else begin
            w_col_nxt = r_col + 1'b1;
          end
        end
      end
      WON: ;
`ifdef GAME_JUDGE_DRAW_DETECT_EN
      DRAW: ;
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_snap   <= '0;
      r_anchor <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_over   <= 1'b0;
      r_winner <= 2'b00;
      r_mask   <= '0;
`ifdef GAME_JUDGE_DRAW_DETECT_EN
      r_draw   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_snap   <= w_snap_nxt;
      r_anchor <= w_anchor_nxt;
      r_row    <= w_row_nxt;
      r_col    <= w_col_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_over   <= w_over_nxt;
      r_winner <= w_winner_nxt;
      r_mask   <= w_mask_nxt;
`ifdef GAME_JUDGE_DRAW_DETECT_EN
      r_draw   <= w_draw_nxt;
`endif
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign game_over = r_over;
  assign winner    = r_winner;
  assign win_mask  = r_mask;

endmodule

// File: tb/tb_game_judge.sv
// Directed bench for game_judge: one 3x3/K=3 instance and one 5x5/K=4 instance.
module tb_game_judge;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start3 = 1'b0, start5 = 1'b0;
  logic [17:0] tiles3 = '0;
  logic [49:0] tiles5 = '0;
  logic        busy3, done3, over3, draw3, busy5, done5, over5, draw5;
  logic [1:0]  win3, win5;
  logic [8:0]  mask3;
  logic [24:0] mask5;

  int total = 0;
  int bad = 0;
  int cyc;

  game_judge #(.N(3), .K(3)) u3 (
    .clk(clk), .reset(reset), .start(start3), .tiles(tiles3),
    .busy(busy3), .done(done3), .game_over(over3), .winner(win3),
    .draw(draw3), .win_mask(mask3));

  game_judge #(.N(5), .K(4)) u5 (
    .clk(clk), .reset(reset), .start(start5), .tiles(tiles5),
    .busy(busy5), .done(done5), .game_over(over5), .winner(win5),
    .draw(draw5), .win_mask(mask5));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic go3();
    @(negedge clk); start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
  endtask

  task automatic go5();
    @(negedge clk); start5 = 1'b1;
    @(posedge clk); #1; start5 = 1'b0;
  endtask

  task automatic wait3(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done3 && n < 40);
  endtask

  task automatic wait5(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done5 && n < 60);
  endtask

  task automatic set3(input int idx, input logic [1:0] v);
    tiles3[2*idx +: 2] = v;
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst_busy", busy3, 0);
    chk("rst_done", done3, 0);
    chk("rst_over", over3, 0);
    chk("rst_winner", win3, 0);
    chk("rst_draw", draw3, 0);
    chk("rst_mask", mask3, 0);

    // Bottom row player 2: anchor 6, H
    tiles3 = '0; set3(6, 2'b10); set3(7, 2'b10); set3(8, 2'b10);
    go3();
    chk("t1_busy", busy3, 1);
    tiles3 = '0;  // must be ignored during the scan
    wait3(cyc);
    chk("t1_lat", cyc, 7);
    chk("t1_winner", win3, 2'b10);
    chk("t1_mask", mask3, 9'b111000000);
    chk("t1_over", over3, 1);
    chk("t1_busy_end", busy3, 0);
    @(posedge clk); #1;
    chk("t1_done_pulse", done3, 0);
    // WON is terminal: start ignored
    go3();
    repeat (3) @(posedge clk); #1;
    chk("t1_sticky_busy", busy3, 0);
    chk("t1_sticky_win", win3, 2'b10);
    chk("t1_sticky_mask", mask3, 9'b111000000);

    // Anti-diagonal 2,4,6 player 1
    do_reset();
    tiles3 = '0; set3(2, 2'b01); set3(4, 2'b01); set3(6, 2'b01);
    go3(); wait3(cyc);
    chk("t2_lat", cyc, 3);
    chk("t2_winner", win3, 2'b01);
    chk("t2_mask", mask3, 9'b001010100);

    // Row 0 and column 0 both win at anchor 0: H has priority
    do_reset();
    tiles3 = '0;
    set3(0, 2'b01); set3(1, 2'b01); set3(2, 2'b01); set3(3, 2'b01); set3(6, 2'b01);
    go3(); wait3(cyc);
    chk("t3_lat", cyc, 1);
    chk("t3_mask", mask3, 9'b000000111);
    chk("t3_winner", win3, 2'b01);

    // Invalid cells never win
    do_reset();
    tiles3 = '0; set3(3, 2'b11); set3(4, 2'b11); set3(5, 2'b11);
    go3(); wait3(cyc);
    chk("t4_lat", cyc, 9);
    chk("t4_winner", win3, 0);
    chk("t4_over", over3, 0);

    // Full board, no line
    do_reset();
    set3(0, 2'b01); set3(1, 2'b10); set3(2, 2'b01);
    set3(3, 2'b10); set3(4, 2'b10); set3(5, 2'b01);
    set3(6, 2'b01); set3(7, 2'b01); set3(8, 2'b10);
    go3(); wait3(cyc);
    chk("t5_lat", cyc, 9);
    chk("t5_winner", win3, 0);
    chk("t5_mask", mask3, 0);
    chk("t5_busy", busy3, 0);
`ifdef GAME_JUDGE_DRAW_DETECT_EN
    chk("t5_draw", draw3, 1);
    chk("t5_over", over3, 1);
`else
    chk("t5_draw", draw3, 0);
    chk("t5_over", over3, 0);
`endif
    go3();
`ifdef GAME_JUDGE_DRAW_DETECT_EN
    chk("t5_restart_busy", busy3, 0);
`else
    chk("t5_restart_busy", busy3, 1);
`endif

    // 5x5, K=4: diagonal 6,12,18,24 player 2
    do_reset();
    tiles5 = '0;
    tiles5[2*6 +: 2] = 2'b10; tiles5[2*12 +: 2] = 2'b10;
    tiles5[2*18 +: 2] = 2'b10; tiles5[2*24 +: 2] = 2'b10;
    go5(); wait5(cyc);
    chk("t6_lat", cyc, 7);
    chk("t6_winner", win5, 2'b10);
    chk("t6_mask", mask5, 25'h1041040);
    chk("t6_over", over5, 1);

    // Reset in the third scan cycle aborts without a done pulse
    do_reset();
    tiles3 = '0; set3(6, 2'b10); set3(7, 2'b10); set3(8, 2'b10);
    go3();
    @(posedge clk); @(posedge clk); #1;
    chk("t7_busy_mid", busy3, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t7_busy", busy3, 0);
    chk("t7_done", done3, 0);
    chk("t7_over", over3, 0);
    chk("t7_winner", win3, 0);
    chk("t7_mask", mask3, 0);
    cyc = 0;
    repeat (10) begin @(posedge clk); #1; if (done3) cyc++; end
    chk("t7_no_done", cyc, 0);
    go3(); wait3(cyc);
    chk("t7_lat", cyc, 7);
    chk("t7_winner2", win3, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
